// File: rtl/clk_div_sequencer.sv
// rtl/clk_div_sequencer.sv - programmable toggle divider with start/stop parking, bursts and
// handshaked divisor reconfiguration applied only on half-period boundaries.
module clk_div_sequencer #(
    parameter int WIDTH       = 9,
    parameter int DEFAULT_DIV = 500,
    parameter int BWIDTH      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WIDTH-1:0]  cfg_div,
    input  logic [BWIDTH-1:0] cfg_burst,
    input  logic              start,
    input  logic              stop,
    output logic              clk_out,
    output logic              tick,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PARK = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]  DEF_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0]  ONE_W    = WIDTH'(1);
    localparam logic [BWIDTH-1:0] ONE_B    = BWIDTH'(1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  div_active_q, div_active_d;
    logic [WIDTH-1:0]  pend_div_q, pend_div_d;
    logic [BWIDTH-1:0] burst_active_q, burst_active_d;
    logic [BWIDTH-1:0] pend_burst_q, pend_burst_d;
    logic [BWIDTH-1:0] fcnt_q, fcnt_d;
    logic              pend_valid_q, pend_valid_d;
    logic              clk_out_q, clk_out_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              at_boundary;
    logic              fall_edge;
    logic              commit_en;
    logic [BWIDTH-1:0] fcnt_inc;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        div_active_d   = div_active_q;
        burst_active_d = burst_active_q;
        pend_div_d     = pend_div_q;
        pend_burst_d   = pend_burst_q;
        pend_valid_d   = pend_valid_q;
        fcnt_d         = fcnt_q;
        clk_out_d      = clk_out_q;
        tick_d         = 1'b0;
        done_d         = 1'b0;

        at_boundary = (cnt_q == div_active_q);
        fall_edge   = at_boundary && clk_out_q;
        fcnt_inc    = fcnt_q + ONE_B;

        // Pending config lands immediately when idle, otherwise only where a half-period ends,
        // so the half-period in flight keeps the divisor it started with.
        commit_en = pend_valid_q && ((state_q == IDLE) || at_boundary);

        if (commit_en) begin
            div_active_d   = pend_div_q;
            burst_active_d = pend_burst_q;
            pend_valid_d   = 1'b0;
        end else if (cfg_valid && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_div_d   = (cfg_div == '0) ? ONE_W : cfg_div;
            pend_burst_d = cfg_burst;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                if (start && !stop) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end
            end

            RUN: begin
                if (at_boundary) begin
                    cnt_d     = '0;
                    clk_out_d = ~clk_out_q;
                    tick_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_W;
                end

                if (fall_edge) begin
                    fcnt_d = fcnt_inc;
                    // A stop coinciding with a fall needs no parking: the output is already going low.
                    if (((burst_active_q != '0) && (fcnt_inc == burst_active_q)) || stop) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (stop) begin
                    if (!clk_out_q && (cnt_q == '0)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PARK;
                    end
                end
            end

            PARK: begin
                // A low phase finishes without toggling; a high phase ends with its normal fall.
                if (at_boundary) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    tick_d    = clk_out_q;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_W;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            div_active_q   <= DEF_DIV;
            burst_active_q <= '0;
            pend_div_q     <= '0;
            pend_burst_q   <= '0;
            pend_valid_q   <= 1'b0;
            fcnt_q         <= '0;
            clk_out_q      <= 1'b0;
            tick_q         <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            div_active_q   <= div_active_d;
            burst_active_q <= burst_active_d;
            pend_div_q     <= pend_div_d;
            pend_burst_q   <= pend_burst_d;
            pend_valid_q   <= pend_valid_d;
            fcnt_q         <= fcnt_d;
            clk_out_q      <= clk_out_d;
            tick_q         <= tick_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
        end
    end

    assign cfg_ready = ~pend_valid_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// tb/tb_clk_div_sequencer.sv - scoreboard bench: expected toggles queued at stimulus time,
// popped and compared whenever the divider ticks.
module tb_clk_div_sequencer;

    localparam int DEF_HALF = 501;

    typedef struct {
        int   cyc;
        logic lvl;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [8:0] cfg_div;
    logic [7:0] cfg_burst;
    logic       start;
    logic       stop;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic       done;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    clk_div_sequencer #(.WIDTH(9), .DEFAULT_DIV(500), .BWIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_burst (cfg_burst),
        .start     (start),
        .stop      (stop),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_cfg(input logic [8:0] d, input logic [7:0] b);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_div   = d;
        cfg_burst = b;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    endtask

    task automatic test_free_run;
        int   e;
        int   done_at;
        int   n_done;
        exp_t ev;
        @(negedge clk);
        start = 1'b1;
        e = cyc + 1;
        for (int k = 1; k <= 4; k++) exp_q.push_back('{cyc: e + k * DEF_HALF, lvl: logic'(k % 2)});
        done_at = e + 4 * DEF_HALF + 1;
        n_done = 0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL free_busy_start: got %b want 1", busy); end
        for (int i = 0; i < 4 * DEF_HALF + 8; i++) begin
            @(negedge clk);
            if (tick) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL free_tick: unexpected tick at cycle %0d", cyc);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc !== ev.cyc || clk_out !== ev.lvl) begin
                        errors++;
                        $display("FAIL free_tick: got cycle %0d clk_out %b, want cycle %0d clk_out %b", cyc, clk_out, ev.cyc, ev.lvl);
                    end
                end
            end
            if (done) begin
                checks++; n_done++;
                if (cyc !== done_at) begin errors++; $display("FAIL free_done: got cycle %0d want %0d", cyc, done_at); end
            end
            if (cyc == e + 1000) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL free_busy_mid: got %b want 1", busy); end
            end
            if (cyc == e + 4 * DEF_HALF) stop = 1'b1;
            if (cyc == done_at) begin
                stop = 1'b0;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL free_busy_end: got %b want 0", busy); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL free_missing: got %0d ticks outstanding want 0", exp_q.size()); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL free_done_count: got %0d want 1", n_done); end
        exp_q.delete();
    endtask

    task automatic test_burst_cfg;
        int   e;
        int   done_at;
        int   n_done;
        exp_t ev;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_div = 9'd3; cfg_burst = 8'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL burst_ready_low: got %b want 0", cfg_ready); end
        @(negedge clk);
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL burst_ready_commit: got %b want 1", cfg_ready); end
        start = 1'b1;
        e = cyc + 1;
        for (int k = 1; k <= 4; k++) exp_q.push_back('{cyc: e + k * 4, lvl: logic'(k % 2)});
        done_at = e + 16;
        n_done = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (tick) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL burst_tick: unexpected tick at cycle %0d", cyc);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc !== ev.cyc || clk_out !== ev.lvl) begin
                        errors++;
                        $display("FAIL burst_tick: got cycle %0d clk_out %b, want cycle %0d clk_out %b", cyc, clk_out, ev.cyc, ev.lvl);
                    end
                end
            end
            if (done) begin
                checks++; n_done++;
                if (cyc !== done_at) begin errors++; $display("FAIL burst_done: got cycle %0d want %0d", cyc, done_at); end
            end
            if (cyc == done_at) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end: got %b want 0", busy); end
            end
        end
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL burst_parked: got %b want 0", clk_out); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL burst_missing: got %0d ticks outstanding want 0", exp_q.size()); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL burst_done_count: got %0d want 1", n_done); end
        exp_q.delete();
    endtask

    task automatic test_reconfig;
        int   e;
        int   done_at;
        int   n_done;
        exp_t ev;
        do_cfg(9'd3, 8'd0);
        start = 1'b1;
        e = cyc + 1;
        exp_q.push_back('{cyc: e + 4,  lvl: 1'b1});
        exp_q.push_back('{cyc: e + 8,  lvl: 1'b0});
        exp_q.push_back('{cyc: e + 10, lvl: 1'b1});
        exp_q.push_back('{cyc: e + 12, lvl: 1'b0});
        done_at = e + 13;
        n_done = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tick) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL reconfig_tick: unexpected tick at cycle %0d", cyc);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc !== ev.cyc || clk_out !== ev.lvl) begin
                        errors++;
                        $display("FAIL reconfig_tick: got cycle %0d clk_out %b, want cycle %0d clk_out %b", cyc, clk_out, ev.cyc, ev.lvl);
                    end
                end
            end
            if (done) begin
                checks++; n_done++;
                if (cyc !== done_at) begin errors++; $display("FAIL reconfig_done: got cycle %0d want %0d", cyc, done_at); end
            end
            if (cyc == e + 4) begin
                cfg_valid = 1'b1; cfg_div = 9'd1; cfg_burst = 8'd0;
            end
            if (cyc == e + 5) cfg_valid = 1'b0;
            if (cyc == e + 7) begin
                checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reconfig_ready_held: got %b want 0", cfg_ready); end
            end
            if (cyc == e + 8) begin
                checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reconfig_ready_commit: got %b want 1", cfg_ready); end
            end
            if (cyc == e + 12) stop = 1'b1;
            if (cyc == done_at) stop = 1'b0;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reconfig_missing: got %0d ticks outstanding want 0", exp_q.size()); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL reconfig_done_count: got %0d want 1", n_done); end
        exp_q.delete();
    endtask

    task automatic test_stop_park;
        int   e;
        int   stop_at;
        int   done_at;
        int   n_done;
        exp_t ev;
        do_cfg(9'd3, 8'd0);
        for (int sc = 0; sc < 2; sc++) begin
            @(negedge clk);
            start = 1'b1;
            e = cyc + 1;
            exp_q.push_back('{cyc: e + 4, lvl: 1'b1});
            exp_q.push_back('{cyc: e + 8, lvl: 1'b0});
            stop_at = (sc == 0) ? e + 4 : e + 9;
            done_at = (sc == 0) ? e + 8 : e + 12;
            n_done = 0;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 18; i++) begin
                @(negedge clk);
                if (tick) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL park%0d_tick: unexpected tick at cycle %0d", sc, cyc);
                    end else begin
                        ev = exp_q.pop_front();
                        if (cyc !== ev.cyc || clk_out !== ev.lvl) begin
                            errors++;
                            $display("FAIL park%0d_tick: got cycle %0d clk_out %b, want cycle %0d clk_out %b", sc, cyc, clk_out, ev.cyc, ev.lvl);
                        end
                    end
                end
                if (done) begin
                    checks++; n_done++;
                    if (cyc !== done_at) begin errors++; $display("FAIL park%0d_done: got cycle %0d want %0d", sc, cyc, done_at); end
                end
                if (cyc == stop_at + 2) begin
                    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL park%0d_busy: got %b want 1", sc, busy); end
                end
                if (cyc == stop_at) stop = 1'b1;
                if (cyc == done_at) stop = 1'b0;
            end
            checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL park%0d_low: got %b want 0", sc, clk_out); end
            checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL park%0d_missing: got %0d outstanding want 0", sc, exp_q.size()); end
            checks++; if (n_done != 1) begin errors++; $display("FAIL park%0d_done_count: got %0d want 1", sc, n_done); end
            exp_q.delete();
        end
    endtask

    task automatic test_div_zero;
        int   e;
        int   done_at;
        int   n_done;
        exp_t ev;
        do_cfg(9'd0, 8'd1);
        start = 1'b1;
        e = cyc + 1;
        exp_q.push_back('{cyc: e + 2, lvl: 1'b1});
        exp_q.push_back('{cyc: e + 4, lvl: 1'b0});
        done_at = e + 4;
        n_done = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tick) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL divzero_tick: unexpected tick at cycle %0d", cyc);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc !== ev.cyc || clk_out !== ev.lvl) begin
                        errors++;
                        $display("FAIL divzero_tick: got cycle %0d clk_out %b, want cycle %0d clk_out %b", cyc, clk_out, ev.cyc, ev.lvl);
                    end
                end
            end
            if (done) begin
                checks++; n_done++;
                if (cyc !== done_at) begin errors++; $display("FAIL divzero_done: got cycle %0d want %0d", cyc, done_at); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL divzero_missing: got %0d outstanding want 0", exp_q.size()); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL divzero_done_count: got %0d want 1", n_done); end
        exp_q.delete();

        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (busy !== 1'b0 || tick !== 1'b0 || clk_out !== 1'b0) begin
                errors++; $display("FAIL start_stop_idle: got busy %b tick %b clk_out %b want 0 0 0", busy, tick, clk_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        int   e;
        int   done_at;
        int   n_done;
        exp_t ev;
        do_cfg(9'd3, 8'd0);
        start = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e + 6) begin
            @(negedge clk);
            if (cyc == e + 4) begin
                checks++;
                if (tick !== 1'b1 || clk_out !== 1'b1) begin errors++; $display("FAIL rstmid_rise: got tick %b clk_out %b want 1 1", tick, clk_out); end
            end
            if (cyc == e + 5) begin
                cfg_valid = 1'b1; cfg_div = 9'd7; cfg_burst = 8'd0;
            end
        end
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got cfg_ready %b want 0", cfg_ready); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (clk_out !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0 || tick !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: got clk_out %b cfg_ready %b busy %b tick %b want 0 1 0 0", clk_out, cfg_ready, busy, tick);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start = 1'b1;
        e = cyc + 1;
        exp_q.push_back('{cyc: e + DEF_HALF,     lvl: 1'b1});
        exp_q.push_back('{cyc: e + 2 * DEF_HALF, lvl: 1'b0});
        done_at = e + 2 * DEF_HALF;
        n_done = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2 * DEF_HALF + 8; i++) begin
            @(negedge clk);
            if (tick) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rstmid_tick: unexpected tick at cycle %0d", cyc);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc !== ev.cyc || clk_out !== ev.lvl) begin
                        errors++;
                        $display("FAIL rstmid_tick: got cycle %0d clk_out %b, want cycle %0d clk_out %b", cyc, clk_out, ev.cyc, ev.lvl);
                    end
                end
            end
            if (done) begin
                checks++; n_done++;
                if (cyc !== done_at) begin errors++; $display("FAIL rstmid_done: got cycle %0d want %0d", cyc, done_at); end
            end
            if (cyc == e + DEF_HALF + 1) stop = 1'b1;
            if (cyc == done_at) stop = 1'b0;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_missing: got %0d outstanding want 0", exp_q.size()); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL rstmid_done_count: got %0d want 1", n_done); end
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_burst = '0;
        start     = 1'b0;
        stop      = 1'b0;
        test_reset();
        test_free_run();
        test_burst_cfg();
        test_reconfig();
        test_stop_park();
        test_div_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_sequencer.md
# clk_div_sequencer

- Programmable replacement for the fixed 100 MHz to ~100 kHz toggle divider.
- Owns the divide counter and sequences it:
  - start/stop with glitch-free parking of the output low;
  - finite bursts of output periods;
  - safe reconfiguration of the divisor via a valid/ready handshake, applied only at half-period boundaries.
- Sits between the control logic and any downstream block that consumes the slow clock/tick.

## Interface
- WIDTH, 9: divide counter and divisor width.
- DEFAULT_DIV, 500: active divisor after reset. Half-period is DEFAULT_DIV+1 cycles, giving ~99.8 kHz from 100 MHz.
- BWIDTH, 8: burst count width.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration slot free.
- cfg_div  in  WIDTH  new divisor; 0 is clamped to 1.
- cfg_burst  in  BWIDTH  full output periods per run; 0 means free-running.
- start  in  1  level-sampled start request.
- stop  in  1  level-sampled stop request.
- clk_out  out  1  divided output, registered.
- tick  out  1  one-cycle pulse on every clk_out toggle.
- busy  out  1  high in RUN or PARK.
- done  out  1  one-cycle pulse on return to IDLE.

## Operation
- Reset values:
  - Outputs: clk_out=0, tick=0, done=0, busy=0, cfg_ready=1.
  - Internals: cnt=0, state=IDLE, div_active=DEFAULT_DIV, burst_active=0, pending empty.
- Counter runs in RUN and PARK only; it is held at 0 in IDLE.
  - If cnt==div_active: cnt<=0, clk_out<=~clk_out, tick<=1.
  - Else: cnt<=cnt+1, tick<=0.
- Config handshake:
  - A transfer occurs when cfg_valid&&cfg_ready on an edge; cfg_div and cfg_burst are captured into the pending register and cfg_ready goes low.
  - In IDLE, pending is committed to div_active/burst_active on the next edge.
  - In RUN/PARK, pending is committed on the edge where cnt==div_active, so the new divisor governs the following half-period. The current half-period is never truncated or stretched.
  - cfg_ready returns high on the edge of commit.
- FSM states:
  - IDLE: start && !stop goes to RUN with cnt=0 and the falling-toggle counter fcnt=0. start and stop together stays in IDLE. A stop alone is ignored.
  - RUN:
    - Every falling toggle (clk_out 1 to 0) increments fcnt.
    - If burst_active!=0 and the incremented fcnt==burst_active, go to IDLE and pulse done.
    - stop while clk_out=0 and cnt==0 goes to IDLE with done. Otherwise stop goes to PARK.
    - start in RUN is ignored.
  - PARK: keep counting until the next falling toggle, then go to IDLE with done. If clk_out=0 on entry, finish the current low half-period without toggling, then go to IDLE on cnt==div_active.
- clk_out is always 0 in IDLE. No high phase is ever shorter than div_active+1 cycles.
- Burst and divisor change mid-burst: fcnt is not reset on commit. The new burst_active is compared from the next falling toggle.
- Asynchronous reset mid-operation returns everything to reset values immediately. Pending config is discarded.

## Timing
- Start sampled at edge E: busy=1 after E, and clk_out rises at edge E+div_active+1 together with the first tick.
- Toggle spacing is exactly div_active+1 cycles, so output period = 2·(div_active+1).
- Burst of N: N rising and N falling toggles. done pulses on the edge of the Nth falling toggle, and busy=0 from that edge.
- Stop latency is at most 2·(div_active+1) cycles.
- Config commit latency:
  - IDLE: 1 cycle.
  - Running: up to div_active+1 cycles.

## Test plan
- Reset then start with DEFAULT_DIV=500 -> clk_out toggles every 501 cycles, tick aligned with each toggle, busy=1, done never pulses.
- Config in IDLE with cfg_div=3, cfg_burst=2, then start -> 2 periods of 8 cycles (4 high/4 low), done pulse at the 2nd fall, busy=0, clk_out=0 after.
- Free run with div=3; config cfg_div=1 offered mid high half-period -> cfg_ready low until that half-period ends at 4 cycles, then 2-cycle halves; cfg_ready high again.
- Free run with div=3; stop asserted 1 cycle after a rising toggle -> PARK, clk_out falls 4 cycles after the rise, done pulses, IDLE, clk_out stays 0.
- cfg_div=0 with burst 1 -> treated as 1: 2-cycle high, 2-cycle low, done. start and stop in the same IDLE cycle -> no activity.
- Assert reset mid-high-phase with a pending config -> clk_out=0 immediately, cfg_ready=1, div_active=500 on the next start.
